// File: rtl/ps2_kbd_pkg.sv
// ---------------------------------------------------------------------------
// ps2_kbd_pkg
// Shared definitions for the PS/2 set-2 keyboard decoder:
//   - scan-code constants for the prefix bytes and the modifier keys
//   - decoder FSM state encoding
//   - ASCII constants
//   - pure lookup functions mapping a scan code to letters, digits and
//     fixed symbols (no state, no parameters)
// ---------------------------------------------------------------------------
package ps2_kbd_pkg;

    // Scan codes with special meaning to the decoder
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // ASCII constants
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    // Decoder FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] value;
    } digit_hit_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] code;
    } sym_hit_t;

    // Uppercase letter for a scan code, or 8'h00 if the code is not a letter
    function automatic logic [7:0] letter_upper(input logic [7:0] sc);
        case (sc)
            8'h1C: return 8'h41; // A
            8'h32: return 8'h42; // B
            8'h21: return 8'h43; // C
            8'h23: return 8'h44; // D
            8'h24: return 8'h45; // E
            8'h2B: return 8'h46; // F
            8'h34: return 8'h47; // G
            8'h33: return 8'h48; // H
            8'h43: return 8'h49; // I
            8'h3B: return 8'h4A; // J
            8'h42: return 8'h4B; // K
            8'h4B: return 8'h4C; // L
            8'h3A: return 8'h4D; // M
            8'h31: return 8'h4E; // N
            8'h44: return 8'h4F; // O
            8'h4D: return 8'h50; // P
            8'h15: return 8'h51; // Q
            8'h2D: return 8'h52; // R
            8'h1B: return 8'h53; // S
            8'h2C: return 8'h54; // T
            8'h3C: return 8'h55; // U
            8'h2A: return 8'h56; // V
            8'h1D: return 8'h57; // W
            8'h22: return 8'h58; // X
            8'h35: return 8'h59; // Y
            8'h1A: return 8'h5A; // Z
            default: return 8'h00;
        endcase
    endfunction

    // Top-row digit keys
    function automatic digit_hit_t digit_value(input logic [7:0] sc);
        case (sc)
            8'h45: return '{hit: 1'b1, value: 4'd0};
            8'h16: return '{hit: 1'b1, value: 4'd1};
            8'h1E: return '{hit: 1'b1, value: 4'd2};
            8'h26: return '{hit: 1'b1, value: 4'd3};
            8'h25: return '{hit: 1'b1, value: 4'd4};
            8'h2E: return '{hit: 1'b1, value: 4'd5};
            8'h36: return '{hit: 1'b1, value: 4'd6};
            8'h3D: return '{hit: 1'b1, value: 4'd7};
            8'h3E: return '{hit: 1'b1, value: 4'd8};
            8'h46: return '{hit: 1'b1, value: 4'd9};
            default: return '{hit: 1'b0, value: 4'd0};
        endcase
    endfunction

    // Symbol printed on a digit key when Shift is held: ")!@#$%^&*("
    function automatic logic [7:0] shifted_digit(input logic [3:0] d);
        case (d)
            4'd0: return 8'h29;
            4'd1: return 8'h21;
            4'd2: return 8'h40;
            4'd3: return 8'h23;
            4'd4: return 8'h24;
            4'd5: return 8'h25;
            4'd6: return 8'h5E;
            4'd7: return 8'h26;
            4'd8: return 8'h2A;
            default: return 8'h28;
        endcase
    endfunction

    // Keys whose character does not depend on Shift or CapsLock
    function automatic sym_hit_t fixed_symbol(input logic [7:0] sc);
        case (sc)
            8'h29: return '{hit: 1'b1, code: 8'h20}; // space
            8'h5A: return '{hit: 1'b1, code: 8'h0D}; // enter
            8'h66: return '{hit: 1'b1, code: 8'h08}; // backspace
            8'h0D: return '{hit: 1'b1, code: 8'h09}; // tab
            8'h0E: return '{hit: 1'b1, code: 8'h7E};
            8'h4E: return '{hit: 1'b1, code: 8'h5F};
            8'h55: return '{hit: 1'b1, code: 8'h2B};
            8'h54: return '{hit: 1'b1, code: 8'h7B};
            8'h5B: return '{hit: 1'b1, code: 8'h7D};
            8'h5D: return '{hit: 1'b1, code: 8'h7C};
            8'h4C: return '{hit: 1'b1, code: 8'h3A};
            8'h52: return '{hit: 1'b1, code: 8'h22};
            8'h41: return '{hit: 1'b1, code: 8'h3C};
            8'h49: return '{hit: 1'b1, code: 8'h3E};
            8'h4A: return '{hit: 1'b1, code: 8'h3F};
            default: return '{hit: 1'b0, code: 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with a sticky overflow flag.
//   clk50     in   clock
//   reset     in   asynchronous active-low reset
//   wr_en     in   write request
//   wr_data   in   write data
//   rd_en     in   pop request (ignored while empty)
//   rd_data   out  head entry, 0 while empty
//   empty     out  no entries stored
//   overflow  out  sticky: a write was dropped because the FIFO was full
// A write to a full FIFO is accepted when a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    // Gate the head with empty so the output reads 0 after reset even though
    // the storage array itself holds undefined data.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset -- only pointers and count need
    // a defined value, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk50) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// ---------------------------------------------------------------------------
// ps2_ascii_decoder
// Turns PS/2 set-2 scan bytes into case-correct ASCII, tracking the F0
// (break) and E0 (extended) prefixes plus Shift and CapsLock, and queues the
// characters in a show-ahead FIFO with a valid/ready handshake.
//   clk50        in   system clock
//   reset        in   asynchronous active-low reset
//   scan_vld     in   scan byte valid; one byte per 0->1 edge
//   scan_data    in   scan byte, sampled in the edge cycle
//   ascii_rdy    in   consumer ready; pop when ascii_vld & ascii_rdy
//   ascii_vld    out  FIFO not empty
//   ascii_data   out  FIFO head
//   shift_state  out  either Shift key held
//   caps_state   out  CapsLock toggle state
//   overflow     out  sticky: a character was dropped on a full FIFO
// Latency: byte edge in cycle N, decoded character registered in N+1 and
// written into the FIFO at the end of N+1.
// ---------------------------------------------------------------------------
module ps2_ascii_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter bit         LOWERCASE_EN = 1'b1,
    parameter logic [7:0] DEFAULT_CHAR = 8'h2A
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       scan_vld,
    input  logic [7:0] scan_data,
    input  logic       ascii_rdy,
    output logic       ascii_vld,
    output logic [7:0] ascii_data,
    output logic       shift_state,
    output logic       caps_state,
    output logic       overflow
);
    kbd_state_t state;
    logic       scan_vld_q;
    logic       accept;
    logic       shift;
    logic       caps;
    logic       caps_held;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] make_char;
    logic [7:0] letter;
    digit_hit_t digit;
    sym_hit_t   sym;
    logic       fifo_empty;

    // A level held high on scan_vld yields exactly one byte.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            scan_vld_q <= 1'b0;
        end else begin
            scan_vld_q <= scan_vld;
        end
    end

    assign accept = scan_vld & ~scan_vld_q;

    // Character for a plain make code. Modifier keys never reach this value
    // because the FSM handles them before emitting.
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        make_char = DEFAULT_CHAR;
        letter    = letter_upper(scan_data);
        digit     = digit_value(scan_data);
        sym       = fixed_symbol(scan_data);
        if (letter != 8'h00) begin
            // Shift and CapsLock cancel each other out for letters.
            if ((shift ^ caps) || !LOWERCASE_EN) begin
                make_char = letter;
            end else begin
                make_char = letter | ASCII_CASE_BIT;
            end
        end else if (digit.hit) begin
            make_char = shift ? shifted_digit(digit.value)
                              : ASCII_ZERO + {4'h0, digit.value};
        end else if (sym.hit) begin
            make_char = sym.code;
        end
    end

    // Prefix tracking, modifier state and the registered decode result.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shift     <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (scan_data == SC_BREAK) begin
                            state <= ST_BRK;
                        end else if (scan_data == SC_EXT) begin
                            state <= ST_EXT;
                        end else if (scan_data == SC_LSHIFT || scan_data == SC_RSHIFT) begin
                            shift <= 1'b1;
                        end else if (scan_data == SC_CAPS) begin
                            // Typematic repeats arrive as further makes while
                            // the key is down; only the first one toggles.
                            if (!caps_held) begin
                                caps <= ~caps;
                            end
                            caps_held <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= make_char;
                        end
                    end
                    ST_BRK: begin
                        // Both Shift keys share one flag; releasing either clears it.
                        if (scan_data == SC_LSHIFT || scan_data == SC_RSHIFT) begin
                            shift <= 1'b0;
                        end else if (scan_data == SC_CAPS) begin
                            caps_held <= 1'b0;
                        end
                        state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (scan_data == SC_BREAK) begin
                            state <= ST_EXT_BRK;
                        end else begin
                            // Keypad Enter is the only extended key we emit.
                            if (scan_data == SC_ENTER) begin
                                wr_en   <= 1'b1;
                                wr_data <= ASCII_CR;
                            end
                            state <= ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk50    (clk50),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (ascii_rdy),
        .rd_data  (ascii_data),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign ascii_vld   = ~fifo_empty;
    assign shift_state = shift;
    assign caps_state  = caps;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_ascii_decoder
// Directed scenarios with literal expected characters, followed by a
// randomized scan-byte stream checked against a behavioural keyboard model.
// ---------------------------------------------------------------------------
module tb_ps2_ascii_decoder;

    localparam int         FIFO_DEPTH   = 4;
    localparam bit         LOWERCASE_EN = 1'b1;
    localparam logic [7:0] DEFAULT_CHAR = 8'h2A;

    logic       clk50 = 1'b0;
    logic       reset = 1'b0;
    logic       scan_vld = 1'b0;
    logic [7:0] scan_data = 8'h00;
    logic       ascii_rdy = 1'b0;
    logic       ascii_vld;
    logic [7:0] ascii_data;
    logic       shift_state;
    logic       caps_state;
    logic       overflow;

    always #10 clk50 = ~clk50;

    ps2_ascii_decoder #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .LOWERCASE_EN (LOWERCASE_EN),
        .DEFAULT_CHAR (DEFAULT_CHAR)
    ) dut (
        .clk50       (clk50),
        .reset       (reset),
        .scan_vld    (scan_vld),
        .scan_data   (scan_data),
        .ascii_rdy   (ascii_rdy),
        .ascii_vld   (ascii_vld),
        .ascii_data  (ascii_data),
        .shift_state (shift_state),
        .caps_state  (caps_state),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned got_q[$];   // characters popped from the DUT
    byte unsigned exp_q[$];   // characters predicted by the model
    byte unsigned lit_q[$];   // literal expectation of a directed test

    // ---------------- behavioural keyboard model ----------------
    byte unsigned letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_sc[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    // ")!@#$%^&*("
    byte unsigned digit_sym[10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24,
                                    8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
    byte unsigned punct_sc[15]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h0E, 8'h4E, 8'h55, 8'h54,
                                    8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    byte unsigned punct_ch[15]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h7E, 8'h5F, 8'h2B, 8'h7B,
                                    8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

    bit m_brk, m_ext, m_ext_brk;       // pending prefixes
    bit m_shift, m_caps, m_caps_held;  // keyboard modifier state

    function automatic void model_reset();
        m_brk = 0; m_ext = 0; m_ext_brk = 0;
        m_shift = 0; m_caps = 0; m_caps_held = 0;
    endfunction

    function automatic int ref_make(byte unsigned sc);
        for (int i = 0; i < 26; i++) begin
            if (letter_sc[i] == sc) begin
                if ((m_shift ^ m_caps) || !LOWERCASE_EN) return 'h41 + i;
                return 'h61 + i;
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (digit_sc[i] == sc) return m_shift ? int'(digit_sym[i]) : 'h30 + i;
        end
        for (int i = 0; i < 15; i++) begin
            if (punct_sc[i] == sc) return int'(punct_ch[i]);
        end
        return int'(DEFAULT_CHAR);
    endfunction

    function automatic void model_byte(byte unsigned sc);
        int c;
        if (m_ext_brk) begin
            m_ext_brk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (sc == 8'hF0) m_ext_brk = 1;
            else if (sc == 8'h5A) exp_q.push_back(8'h0D);
        end else if (m_brk) begin
            m_brk = 0;
            if (sc == 8'h12 || sc == 8'h59) m_shift = 0;
            else if (sc == 8'h58) m_caps_held = 0;
        end else if (sc == 8'hF0) begin
            m_brk = 1;
        end else if (sc == 8'hE0) begin
            m_ext = 1;
        end else if (sc == 8'h12 || sc == 8'h59) begin
            m_shift = 1;
        end else if (sc == 8'h58) begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1;
        end else begin
            c = ref_make(sc);
            exp_q.push_back(8'(c));
        end
    endfunction

    // ---------------- stimulus primitives ----------------
    // Inputs change on the falling edge; outputs are sampled there too, so a
    // pop is recorded when vld and the freshly driven rdy will meet at the
    // next rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk50);
        scan_vld  = v;
        scan_data = d;
        ascii_rdy = r;
        if (ascii_vld && ascii_rdy) got_q.push_back(ascii_data);
    endtask

    task automatic send_byte(input byte unsigned sc, input logic r_edge, input logic r_after);
        cycle(1'b1, sc, r_edge);
        model_byte(sc);
        cycle(1'b0, sc, r_after);
    endtask

    task automatic drain(input int target);
        int guard = 0;
        while (got_q.size() < target && guard < 80) begin
            cycle(1'b0, 8'h00, 1'b1);
            guard++;
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk50);
        reset = 1'b0; scan_vld = 1'b0; ascii_rdy = 1'b0;
        repeat (2) @(negedge clk50);
        reset = 1'b1;
        model_reset();
        got_q.delete(); exp_q.delete(); lit_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk50);
        reset = 1'b0;
        repeat (2) @(negedge clk50);
        n_checks++; if (ascii_vld !== 1'b0)    begin n_fail++; $display("FAIL reset_vld: got %b want 0", ascii_vld); end
        n_checks++; if (ascii_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h want 00", ascii_data); end
        n_checks++; if (shift_state !== 1'b0)  begin n_fail++; $display("FAIL reset_shift: got %b want 0", shift_state); end
        n_checks++; if (caps_state !== 1'b0)   begin n_fail++; $display("FAIL reset_caps: got %b want 0", caps_state); end
        n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_make_break();
        got_q.delete(); lit_q = '{8'h61};
        send_byte(8'h1C, 1, 1); send_byte(8'hF0, 1, 1); send_byte(8'h1C, 1, 1);
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL make_break_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL make_break_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL make_break_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_shift();
        got_q.delete(); lit_q = '{8'h41, 8'h61};
        send_byte(8'h12, 1, 1);
        n_checks++; if (shift_state !== 1'b1) begin n_fail++; $display("FAIL shift_held: got %b want 1", shift_state); end
        send_byte(8'h1C, 1, 1); send_byte(8'hF0, 1, 1); send_byte(8'h1C, 1, 1);
        send_byte(8'hF0, 1, 1); send_byte(8'h12, 1, 1);
        n_checks++; if (shift_state !== 1'b0) begin n_fail++; $display("FAIL shift_released: got %b want 0", shift_state); end
        send_byte(8'h1C, 1, 1);
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL shift_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL shift_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
    endtask

    task automatic test_caps();
        got_q.delete(); lit_q = '{8'h41, 8'h61};
        send_byte(8'h58, 1, 1); send_byte(8'h58, 1, 1);
        send_byte(8'hF0, 1, 1); send_byte(8'h58, 1, 1);
        n_checks++; if (caps_state !== 1'b1) begin n_fail++; $display("FAIL caps_on: got %b want 1", caps_state); end
        send_byte(8'h1C, 1, 1);
        send_byte(8'h12, 1, 1); send_byte(8'h1C, 1, 1);
        send_byte(8'hF0, 1, 1); send_byte(8'h12, 1, 1);
        send_byte(8'h58, 1, 1); send_byte(8'hF0, 1, 1); send_byte(8'h58, 1, 1);
        n_checks++; if (caps_state !== 1'b0) begin n_fail++; $display("FAIL caps_off: got %b want 0", caps_state); end
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL caps_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL caps_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
    endtask

    task automatic test_ext_default();
        got_q.delete(); lit_q = '{8'h0D, 8'h21, 8'h2A};
        send_byte(8'hE0, 1, 1); send_byte(8'h5A, 1, 1);
        send_byte(8'hE0, 1, 1); send_byte(8'h75, 1, 1);
        send_byte(8'hE0, 1, 1); send_byte(8'hF0, 1, 1); send_byte(8'h75, 1, 1);
        send_byte(8'h12, 1, 1); send_byte(8'h16, 1, 1);
        send_byte(8'hF0, 1, 1); send_byte(8'h12, 1, 1);
        send_byte(8'h07, 1, 1);
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL ext_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL ext_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
    endtask

    task automatic test_fifo_full();
        got_q.delete(); lit_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        // Fill with a, b, c, d while the consumer stalls
        send_byte(8'h1C, 0, 0); send_byte(8'h32, 0, 0);
        send_byte(8'h21, 0, 0); send_byte(8'h23, 0, 0);
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (ascii_vld !== 1'b1 || ascii_data !== 8'h61) begin n_fail++; $display("FAIL full_head: got vld=%b data=%h want vld=1 data=61", ascii_vld, ascii_data); end
        // 'e' lands in the same cycle as the pop of 'a'
        send_byte(8'h24, 0, 1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_ovf: got %b want 0", overflow); end
        n_checks++; if (ascii_data !== 8'h62) begin n_fail++; $display("FAIL full_pop_head: got %h want 62", ascii_data); end
        // 'f' hits a full FIFO with no pop and is dropped
        send_byte(8'h2B, 0, 0);
        void'(exp_q.pop_back());
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_ovf: got %b want 1", overflow); end
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL fifo_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL fifo_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
        n_checks++; if (ascii_vld !== 1'b0) begin n_fail++; $display("FAIL fifo_empty_vld: got %b want 0", ascii_vld); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hE0, 1, 1);
        apply_reset();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf: got %b want 0", overflow); end
        lit_q = '{8'h61};
        send_byte(8'h1C, 1, 1); send_byte(8'hF0, 1, 1); send_byte(8'h1C, 1, 1);
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL midreset_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL midreset_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
    endtask

    task automatic test_held_level();
        got_q.delete(); lit_q = '{8'h61};
        cycle(1'b1, 8'h1C, 1'b1);
        model_byte(8'h1C);
        repeat (9) cycle(1'b1, 8'h1C, 1'b1);
        cycle(1'b0, 8'h1C, 1'b1);
        send_byte(8'hF0, 1, 1); send_byte(8'h1C, 1, 1);
        drain(lit_q.size());
        n_checks++; if (got_q.size() !== lit_q.size()) begin n_fail++; $display("FAIL held_count: got %0d want %0d", got_q.size(), lit_q.size()); end
        foreach (lit_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== lit_q[i]) begin n_fail++; $display("FAIL held_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, lit_q[i]); end
        end
    endtask

    function automatic byte unsigned rand_scan();
        int sel = $urandom_range(0, 99);
        if (sel < 35) return letter_sc[$urandom_range(0, 25)];
        if (sel < 50) return digit_sc[$urandom_range(0, 9)];
        if (sel < 58) return punct_sc[$urandom_range(0, 14)];
        if (sel < 72) return 8'hF0;
        if (sel < 78) return 8'hE0;
        if (sel < 86) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        if (sel < 92) return 8'h58;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_random();
        byte unsigned sc;
        int guard;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            // Keep the FIFO from filling so the model never has to predict drops
            guard = 0;
            while ((exp_q.size() - got_q.size()) >= FIFO_DEPTH - 1 && guard < 100) begin
                cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
                guard++;
            end
            sc = rand_scan();
            send_byte(sc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            n_checks++; if (shift_state !== m_shift) begin n_fail++; $display("FAIL rand_shift[%0d]: got %b want %b", n, shift_state, m_shift); end
            n_checks++; if (caps_state !== m_caps)   begin n_fail++; $display("FAIL rand_caps[%0d]: got %b want %b", n, caps_state, m_caps); end
            repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end
        drain(exp_q.size());
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_ovf: got %b want 0", overflow); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_shift();
        test_caps();
        test_ext_default();
        test_fifo_full();
        test_reset_mid();
        test_held_level();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case a scenario stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
